mux_2_to_1_rr_arbiter: RTL and testbench

- Two-source round-robin arbiter feeding the 2-to-1 mux select path.
- Takes two valid/ready data channels A and B and grants one per transfer. Drives a registered select S (0 = A, 1 = B) and the registered selected data on a single valid/ready output channel.
- Sits directly upstream of the consumer of the muxed stream; S is the select for that transfer.

---
 rtl/mux_2_to_1_rr_arbiter_if.sv | 26 ++
 rtl/mux_2_to_1_rr_arbiter.sv | 71 +++++++
 tb/tb_mux_2_to_1_rr_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mux_2_to_1_rr_arbiter_if.sv
// Valid/ready bundle for the two-source round-robin arbiter:
// sources A and B in, one muxed output channel with its select S.
interface mux_2_to_1_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic             A_valid;
    logic             A_ready;
    logic [WIDTH-1:0] B;
    logic             B_valid;
    logic             B_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             S;

    modport master (
        output A, A_valid, B, B_valid, out_ready,
        input  A_ready, B_ready, out, out_valid, S
    );

    modport slave (
        input  A, A_valid, B, B_valid, out_ready,
        output A_ready, B_ready, out, out_valid, S
    );
endinterface

// File: rtl/mux_2_to_1_rr_arbiter.sv
// Two-source round-robin arbiter with a registered output stage
// that drives the selected word and its select S.
module mux_2_to_1_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input logic                     clk,
    input logic                     rst,
    mux_2_to_1_rr_arbiter_if.slave  bus
);
    logic             can_load;
    logic             gnt_vld;
    logic             gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [WIDTH-1:0] out_q;
    logic             vld_q;
    logic             s_q;
    logic             last_q;

    assign can_load = !vld_q || bus.out_ready;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        unique case (1'b1)
            (bus.A_valid && !bus.B_valid): begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b0;
            end
            (!bus.A_valid && bus.B_valid): begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b1;
            end
            (bus.A_valid && bus.B_valid): begin
                gnt_vld = 1'b1;
                gnt_idx = !last_q;
            end
            default: begin
                gnt_vld = 1'b0;
                gnt_idx = 1'b0;
            end
        endcase
    end

    assign gnt_data = gnt_idx ? bus.B : bus.A;

    // Readies are held low while reset is asserted so nothing is consumed.
    assign bus.A_ready = !rst && can_load && gnt_vld && !gnt_idx;
    assign bus.B_ready = !rst && can_load && gnt_vld && gnt_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            vld_q  <= 1'b0;
            s_q    <= 1'b0;
            last_q <= 1'b1;
        end else if (can_load) begin
            if (gnt_vld) begin
                out_q  <= gnt_data;
                s_q    <= gnt_idx;
                vld_q  <= 1'b1;
                last_q <= gnt_idx;
            end else begin
                vld_q  <= 1'b0;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
    assign bus.S         = s_q;
endmodule

// File: tb/tb_mux_2_to_1_rr_arbiter.sv
// Scoreboard bench for the round-robin arbiter: stimulus pushes the
// expected {S,out} on each accepted input, a monitor pops on output transfers.
module tb_mux_2_to_1_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] q[$];

    always #5 clk = ~clk;

    mux_2_to_1_rr_arbiter_if #(.WIDTH(8)) ifc ();

    mux_2_to_1_rr_arbiter #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [7:0] a,
                         input logic bv, input logic [7:0] b,
                         input logic ordy);
        ifc.A_valid   = av;
        ifc.A         = a;
        ifc.B_valid   = bv;
        ifc.B         = b;
        ifc.out_ready = ordy;
    endtask

    task automatic cycle(input logic av, input logic [7:0] a,
                         input logic bv, input logic [7:0] b,
                         input logic ordy,
                         input logic ear, input logic ebr,
                         input string nm);
        @(posedge clk);
        #1;
        drive(av, a, bv, b, ordy);
        #1;
        chk({nm, "_ready"}, {14'd0, ifc.A_ready, ifc.B_ready},
            {14'd0, ear, ebr});
        if (ear) q.push_back({1'b0, a});
        if (ebr) q.push_back({1'b1, b});
    endtask

    // Output monitor: compare every word the consumer takes.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && ifc.out_valid && ifc.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected none",
                             {ifc.S, ifc.out});
                end else begin
                    e = q.pop_front();
                    chk("out_word", {7'd0, ifc.S, ifc.out}, {7'd0, e});
                end
            end
        end
    end

    initial begin
        drive(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
        // Reset with both sources requesting
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_out", {7'd0, ifc.S, ifc.out}, 16'h0000);
            chk("rst_valid", {15'd0, ifc.out_valid}, 16'h0000);
            chk("rst_ready", {14'd0, ifc.A_ready, ifc.B_ready}, 16'h0000);
        end
        rst = 1'b0;
        #1;
        chk("first_ready", {14'd0, ifc.A_ready, ifc.B_ready}, 16'h0002);
        q.push_back({1'b0, 8'hAA});

        // Single source B
        cycle(1'b0, 8'hEE, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, "single_b");
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "idle0");
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "idle1");
        chk("drain_valid", {15'd0, ifc.out_valid}, 16'h0000);
        chk("drain_hold", {7'd0, ifc.S, ifc.out}, 16'h015A);

        // Round robin, last grant was B so A goes first
        for (int i = 0; i < 7; i++)
            cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1,
                  (i % 2) == 0, (i % 2) == 1, "rr");

        // Backpressure holding A's word
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, "stall");
            chk("stall_out", {7'd0, ifc.S, ifc.out}, 16'h0011);
            chk("stall_valid", {15'd0, ifc.out_valid}, 16'h0001);
        end
        cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, "unstall");

        // Idle cycles keep priority
        cycle(1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "grant_a");
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "idle");
        cycle(1'b1, 8'h44, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, "idle_prio");
        cycle(1'b1, 8'h44, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, "pre_rst");

        // Reset while a stalled word is held: that word is discarded
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        #1;
        chk("mid_rst_ready", {14'd0, ifc.A_ready, ifc.B_ready}, 16'h0000);
        @(posedge clk);
        #1;
        chk("mid_rst_valid", {15'd0, ifc.out_valid}, 16'h0000);
        rst = 1'b0;
        drive(1'b1, 8'h66, 1'b1, 8'h99, 1'b1);
        #1;
        chk("post_rst_ready", {14'd0, ifc.A_ready, ifc.B_ready}, 16'h0002);
        q.push_back({1'b0, 8'h66});

        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "tail0");
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "tail1");
        chk("queue_empty", 16'(q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
